// File: rtl/reg_mem_responder.sv
// Reg-bus register-file target: byte-strobed words, ready Latency cycles after valid (0 = same cycle).
// Requester holds valid until ready; dropping it mid-wait aborts. REG_MEM_RESP_ERR_EN flags bad addresses.
package reg_mem_responder_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } req_default_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } rsp_default_t;

endpackage

module reg_mem_responder #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned NumWords = 16,
  parameter int unsigned Latency  = 1,
  parameter logic [AW-1:0] BaseAddr = '0,
  parameter type req_t = reg_mem_responder_pkg::req_default_t,
  parameter type rsp_t = reg_mem_responder_pkg::rsp_default_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  req_t reg_req_i,
  output rsp_t reg_rsp_o,
  output logic busy_o
);

  localparam int unsigned SW      = DW / 8;
  localparam int unsigned OffBits = $clog2(SW);
  localparam int unsigned IW      = $clog2(NumWords);
  localparam logic [7:0]  CntLoad = (Latency > 0) ? 8'(Latency - 1) : 8'd0;
  localparam logic        HasWait = (Latency != 0);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  state_e        state_q;
  logic [7:0]    cnt_q;
  logic [DW-1:0] mem_q [NumWords];

  logic [AW-1:0] off;
  logic [IW-1:0] idx;
  logic          hit;
  logic          acc_err;
  logic          complete;
  logic          do_write;

  assign off = reg_req_i.addr - BaseAddr;

`ifdef REG_MEM_RESP_ERR_EN
  logic [AW-1:0] idx_full;

  assign idx_full = off >> OffBits;
  assign hit      = idx_full < AW'(NumWords);
  assign idx      = IW'(idx_full);
  assign acc_err  = !hit || ((off & AW'(SW - 1)) != '0);
`else
  // Wrap on the low index bits; the compare only matters for non-power-of-2 depths.
  assign idx     = IW'(off >> OffBits);
  assign hit     = {1'b0, idx} < (IW + 1)'(NumWords);
  assign acc_err = 1'b0;
`endif

  assign complete = rst_ni && reg_req_i.valid &&
                    (((state_q == ST_IDLE) && !HasWait) ||
                     ((state_q == ST_WAIT) && (cnt_q == 8'd0)));

  assign do_write = complete && reg_req_i.write && hit && !acc_err;

  assign busy_o = rst_ni && ((state_q == ST_WAIT) || (reg_req_i.valid && HasWait));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (reg_req_i.valid && HasWait) begin
            cnt_q   <= CntLoad;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A dropped valid abandons the transfer; nothing was committed yet.
          if (!reg_req_i.valid || (cnt_q == 8'd0)) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumWords; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_write) begin
      for (int unsigned b = 0; b < SW; b++) begin
        if (reg_req_i.wstrb[b]) begin
          mem_q[idx][8*b +: 8] <= reg_req_i.wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = complete;
    reg_rsp_o.error = complete && acc_err;
    if (complete && !reg_req_i.write && hit && !acc_err) begin
      reg_rsp_o.rdata = mem_q[idx];
    end
  end

endmodule

// File: tb/tb_reg_mem_responder.sv
// Directed bench: one responder per latency 0..4, hand-computed responses and cycle timing.
module tb_reg_mem_responder;
  import reg_mem_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  req_default_t req  [5];
  rsp_default_t rsp  [5];
  logic         busy [5];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    reg_mem_responder #(
      .AW       (32),
      .DW       (32),
      .NumWords (16),
      .Latency  (g),
      .BaseAddr ('0),
      .req_t    (req_default_t),
      .rsp_t    (rsp_default_t)
    ) u_dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .reg_req_i (req[g]),
      .reg_rsp_o (rsp[g]),
      .busy_o    (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Called one step after a rising edge; returns in the same phase with valid dropped.
  task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input int exp_lat,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int n;
    n = 0;
    req[k] = '{addr: addr, write: wr, wdata: wd, wstrb: st, valid: 1'b1};
    @(negedge clk);
    while (!rsp[k].ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_rdata"}, rsp[k].rdata, exp_rd);
    chk({tag, "_err"}, {31'd0, rsp[k].error}, {31'd0, exp_err});
    next_cyc();
    req[k] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 5; k++) req[k] = '0;
    req[0].valid = 1'b1;
    req[4].valid = 1'b1;
    next_cyc();
    @(negedge clk);
    chk("rst_ready_l0", rsp[0].ready, 1'b0);
    chk("rst_busy_l4", busy[4], 1'b0);
    next_cyc();
    req[0] = '0;
    req[4] = '0;
    rst_n = 1'b1;
    next_cyc();
    @(negedge clk);
    chk("idle_rsp_l1", rsp[1], '0);
    chk("idle_busy_l1", busy[1], 1'b0);
    next_cyc();

    // T1: L=1 full-word write then read
    xfer(1, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 1, 32'h0, 1'b0, "t1_wr");
    xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, 1, 32'hDEADBEEF, 1'b0, "t1_rd");

    // T2: L=0 strobed write, combinational ready
    xfer(0, 1'b1, 32'h8, 32'h11223344, 4'h5, 0, 32'h0, 1'b0, "t2_wr");
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'h00220044, 1'b0, "t2_rd");

    // T3: L=3 back-to-back reads with valid held
    xfer(3, 1'b1, 32'hC, 32'hCAFEF00D, 4'hF, 3, 32'h0, 1'b0, "t3_wr");
    req[3] = '{addr: 32'hC, write: 1'b0, wdata: '0, wstrb: '0, valid: 1'b1};
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("t3_ready_c%0d", c), rsp[3].ready, (c == 3 || c == 7));
      chk($sformatf("t3_busy_c%0d", c), busy[3], (c < 8));
      if (c == 3 || c == 7) chk($sformatf("t3_rdata_c%0d", c), rsp[3].rdata, 32'hCAFEF00D);
      next_cyc();
      if (c == 7) req[3] = '0;
    end

`ifdef REG_MEM_RESP_ERR_EN
    // T4: out-of-range and misaligned accesses flag error and leave memory alone
    xfer(1, 1'b1, 32'h0, 32'h600DF00D, 4'hF, 1, 32'h0, 1'b0, "t4_wr0");
    xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, 1, 32'h0, 1'b1, "t4_rd_oor");
    xfer(1, 1'b1, 32'h2, 32'h55555555, 4'hF, 1, 32'h0, 1'b1, "t4_wr_mis");
    xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 1, 32'h600DF00D, 1'b0, "t4_rd0");
`else
    // T4: index wraps modulo depth and low address bits are ignored
    xfer(1, 1'b1, 32'h0, 32'h0BADCAFE, 4'hF, 1, 32'h0, 1'b0, "t4_wr0");
    xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, 1, 32'h0BADCAFE, 1'b0, "t4_rd_wrap");
    xfer(1, 1'b0, 32'h2, 32'h0, 4'h0, 1, 32'h0BADCAFE, 1'b0, "t4_rd_mis");
`endif

    // T6: L=2 write abandoned in cycle 1, then a zero-strobe write
    xfer(2, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 2, 32'h0, 1'b0, "t6_wr");
    req[2] = '{addr: 32'h10, write: 1'b1, wdata: 32'hFFFFFFFF, wstrb: 4'hF, valid: 1'b1};
    @(negedge clk);
    chk("t6_ready_c0", rsp[2].ready, 1'b0);
    chk("t6_busy_c0", busy[2], 1'b1);
    next_cyc();
    req[2] = '0;
    @(negedge clk);
    chk("t6_ready_c1", rsp[2].ready, 1'b0);
    chk("t6_busy_c1", busy[2], 1'b1);
    next_cyc();
    @(negedge clk);
    chk("t6_busy_c2", busy[2], 1'b0);
    next_cyc();
    xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hA5A5A5A5, 1'b0, "t6_rd");
    xfer(2, 1'b1, 32'h10, 32'h0, 4'h0, 2, 32'h0, 1'b0, "t6_wr_nostrb");
    xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hA5A5A5A5, 1'b0, "t6_rd2");

    // T5: L=4 write interrupted by reset in cycle 2
    xfer(4, 1'b1, 32'h14, 32'h13572468, 4'hF, 4, 32'h0, 1'b0, "t5_pre_wr");
    xfer(4, 1'b0, 32'h14, 32'h0, 4'h0, 4, 32'h13572468, 1'b0, "t5_pre_rd");
    req[4] = '{addr: 32'h14, write: 1'b1, wdata: 32'h77777777, wstrb: 4'hF, valid: 1'b1};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("t5_ready_c%0d", c), rsp[4].ready, 1'b0);
      next_cyc();
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_ready_rst", rsp[4].ready, 1'b0);
    chk("t5_busy_rst", busy[4], 1'b0);
    next_cyc();
    req[4] = '0;
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    xfer(4, 1'b0, 32'h14, 32'h0, 4'h0, 4, 32'h0, 1'b0, "t5_rd");
    xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, 1, 32'h0, 1'b0, "t5_rd_l1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
